// File: rtl/axis_crd_tx.sv
// Credit-flow link transmitter: buffers AXI-Stream beats in a 2-entry FIFO and
// forwards one beat per cycle while credits returned by the far-end receiver last.
module axis_crd_tx #(
    parameter int unsigned n       = 32,
    parameter int unsigned CREDITS = 4
) (
    input  logic                               aclk,
    input  logic                               aresetn,
    input  logic [8*n-1:0]                     in_tdata,
    input  logic                               in_tvalid,
    output logic                               in_tready,
    output logic [8*n-1:0]                     out_tdata,
    output logic                               out_tvalid,
    input  logic                               crd_return,
    output logic [$clog2(CREDITS+1)-1:0]       crd_count,
    output logic                               crd_err,
    output logic                               idle
);

    localparam int unsigned CRD_W = $clog2(CREDITS + 1);
    localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(CREDITS);

    logic [8*n-1:0] r_head, r_tail, r_out_tdata;
    logic [1:0]     r_occ;
    logic           r_in_tready, r_out_tvalid, r_crd_err;
    logic [CRD_W-1:0] r_crd;

    logic [8*n-1:0] w_head_d, w_tail_d, w_out_tdata_d;
    logic [1:0]     w_occ_d;
    logic [CRD_W-1:0] w_crd_d;
    logic           w_push, w_send, w_ovf;

    assign w_push = in_tvalid & r_in_tready;
    assign w_send = (r_occ != 2'd0) & (r_crd != '0);
    assign w_ovf  = crd_return & ~w_send & (r_crd == CRD_MAX);

    always_comb begin
        w_head_d      = r_head;
        w_tail_d      = r_tail;
        w_occ_d       = r_occ + {1'b0, w_push} - {1'b0, w_send};
        w_out_tdata_d = r_out_tdata;
        w_crd_d       = r_crd;

        if (w_send) begin
            w_out_tdata_d = r_head;
        end

        // head is always the oldest entry; tail is only valid when occ == 2
        unique case ({w_push, w_send})
            2'b10: begin
                if (r_occ == 2'd0) w_head_d = in_tdata;
                else               w_tail_d = in_tdata;
            end
            2'b01: begin
                if (r_occ == 2'd2) w_head_d = r_tail;
            end
            2'b11: begin
                if (r_occ == 2'd1) begin
                    w_head_d = in_tdata;
                end else begin
                    w_head_d = r_tail;
                    w_tail_d = in_tdata;
                end
            end
            default: ;
        endcase

        if (w_send & ~crd_return) begin
            w_crd_d = r_crd - 1'b1;
        end else if (~w_send & crd_return & ~w_ovf) begin
            w_crd_d = r_crd + 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_occ        <= 2'd0;
            r_in_tready  <= 1'b0;
            r_out_tvalid <= 1'b0;
            r_out_tdata  <= '0;
            r_crd        <= CRD_MAX;
            r_crd_err    <= 1'b0;
        end else begin
            r_head       <= w_head_d;
            r_tail       <= w_tail_d;
            r_occ        <= w_occ_d;
            r_in_tready  <= (w_occ_d < 2'd2);
            r_out_tvalid <= w_send;
            r_out_tdata  <= w_out_tdata_d;
            r_crd        <= w_crd_d;
            if (w_ovf) r_crd_err <= 1'b1;
        end
    end

    assign in_tready  = r_in_tready;
    assign out_tvalid = r_out_tvalid;
    assign out_tdata  = r_out_tdata;
    assign crd_count  = r_crd;
    assign crd_err    = r_crd_err;
    assign idle       = (r_occ == 2'd0) & ~r_out_tvalid & (r_crd == CRD_MAX);

endmodule
